// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Decides who owns the instruction memory: the CPU fetch stage or a UART program
// loader. Two commands are recognised in the received byte stream:
//   CMD_LOAD, ADDR_H, ADDR_L, CNT_H, CNT_L, {DATA_H, DATA_L} x CNT
//     Writes CNT 16-bit words into instruction memory starting at ADDR, then
//     restarts the CPU at ADDR.
//   CMD_RUN, n
//     Restarts the CPU at n*BANK_STRIDE (n in 1..9) without writing memory.
// The CPU is stalled for the whole command. If the line goes quiet in the
// middle of a command for TIMEOUT cycles, the command is abandoned and err is
// raised. err stays set until the next accepted command byte.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   rx_valid    one-cycle strobe; rx_data holds a received byte
//   rx_data     received byte
//   fetch_pc    CPU fetch PC; drives imem_addr when no load is in progress
//   imem_addr   instruction memory address (combinational)
//   imem_we     one-cycle write enable
//   imem_wdata  write data
//   cpu_stall   freezes PC/pipeline while high
//   pc_load     one-cycle pulse: CPU loads PC from pc_value
//   pc_value    restart PC, zero-extended from ADDR_W
//   err         sticky: timeout or bad bank number
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int         ADDR_W      = 12,
    parameter int         TIMEOUT     = 50000,
    parameter logic [7:0] CMD_LOAD    = 8'hA5,
    parameter logic [7:0] CMD_RUN     = 8'h5A,
    parameter int         BANK_STRIDE = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [15:0]       fetch_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [15:0]       imem_wdata,
    output logic              cpu_stall,
    output logic              pc_load,
    output logic [15:0]       pc_value,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        CNT_H,
        CNT_L,
        DATA_H,
        DATA_L,
        WRITE,
        BANK,
        START
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         byte_hi_q;
    logic [ADDR_W-1:0]  start_addr_q;
    logic [ADDR_W-1:0]  load_ptr_q;
    logic [15:0]        count_q;
    logic [CNT_W-1:0]   idle_cnt_q;
    logic               imem_we_q;
    logic [15:0]        imem_wdata_q;
    logic               cpu_stall_q;
    logic               pc_load_q;
    logic [15:0]        pc_value_q;
    logic               err_q;

    logic [15:0]        rx_word;
    logic [15:0]        bank_prod;
    logic [ADDR_W-1:0]  bank_addr;
    logic               bank_ok;
    logic               counting;
    logic               timeout_hit;

    // High byte captured previously, joined with the byte arriving now.
    assign rx_word   = {byte_hi_q, rx_data};
    assign bank_prod = 16'(rx_data) * 16'(BANK_STRIDE);
    assign bank_addr = bank_prod[ADDR_W-1:0];
    assign bank_ok   = (rx_data >= 8'd1) && (rx_data <= 8'd9);

    // The quiet-line counter only runs while waiting for a byte of a command.
    assign counting    = (state_q != IDLE) && (state_q != WRITE) && (state_q != START);
    assign timeout_hit = counting && !rx_valid && (idle_cnt_q == CNT_W'(TIMEOUT - 1));

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rx_valid && rx_data == CMD_LOAD) state_d = ADDR_H;
                    else if (rx_valid && rx_data == CMD_RUN) state_d = BANK;
                end
                ADDR_H: if (rx_valid) state_d = ADDR_L;
                ADDR_L: if (rx_valid) state_d = CNT_H;
                CNT_H:  if (rx_valid) state_d = CNT_L;
                CNT_L:  if (rx_valid) state_d = (rx_word == 16'd0) ? START : DATA_H;
                DATA_H: if (rx_valid) state_d = DATA_L;
                DATA_L: if (rx_valid) state_d = WRITE;
                WRITE: begin
                    // A byte landing during the write is the next high byte.
                    if (count_q == 16'd1) state_d = START;
                    else                  state_d = rx_valid ? DATA_L : DATA_H;
                end
                BANK:   if (rx_valid) state_d = bank_ok ? START : IDLE;
                START:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            byte_hi_q    <= '0;
            start_addr_q <= '0;
            load_ptr_q   <= '0;
            count_q      <= '0;
            idle_cnt_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_wdata_q <= '0;
            cpu_stall_q  <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_value_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_we_q   <= 1'b0;
            pc_load_q   <= 1'b0;
            cpu_stall_q <= (state_d != IDLE);

            if (rx_valid || !counting) idle_cnt_q <= '0;
            else                       idle_cnt_q <= idle_cnt_q + 1'b1;

            if (timeout_hit) begin
                err_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rx_valid && (rx_data == CMD_LOAD || rx_data == CMD_RUN))
                            err_q <= 1'b0;
                    end
                    ADDR_H, CNT_H, DATA_H: begin
                        if (rx_valid) byte_hi_q <= rx_data;
                    end
                    ADDR_L: begin
                        if (rx_valid) begin
                            start_addr_q <= rx_word[ADDR_W-1:0];
                            load_ptr_q   <= rx_word[ADDR_W-1:0];
                        end
                    end
                    CNT_L: begin
                        if (rx_valid) begin
                            count_q <= rx_word;
                            if (rx_word == 16'd0) begin
                                pc_load_q  <= 1'b1;
                                pc_value_q <= 16'(start_addr_q);
                            end
                        end
                    end
                    DATA_L: begin
                        if (rx_valid) begin
                            imem_we_q    <= 1'b1;
                            imem_wdata_q <= rx_word;
                        end
                    end
                    WRITE: begin
                        load_ptr_q <= load_ptr_q + 1'b1;
                        count_q    <= count_q - 16'd1;
                        if (rx_valid) byte_hi_q <= rx_data;
                        if (count_q == 16'd1) begin
                            pc_load_q  <= 1'b1;
                            pc_value_q <= 16'(start_addr_q);
                        end
                    end
                    BANK: begin
                        if (rx_valid) begin
                            if (bank_ok) begin
                                start_addr_q <= bank_addr;
                                pc_load_q    <= 1'b1;
                                pc_value_q   <= 16'(bank_addr);
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_addr  = (state_q == DATA_H || state_q == DATA_L || state_q == WRITE)
                        ? load_ptr_q : fetch_pc[ADDR_W-1:0];
    assign imem_we    = imem_we_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_stall  = cpu_stall_q;
    assign pc_load    = pc_load_q;
    assign pc_value   = pc_value_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed bench for imem_boot_loader. A table of command byte streams with
// hand-computed writes, restart PC, stall length and err is applied first;
// hand-written sequences then cover back-to-back bytes with address wrap, the
// quiet-line timeout and an asynchronous reset in the middle of a load.
// A monitor samples outputs on the falling edge and logs writes, pc_load
// pulses and stalled cycles.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 64;

    logic              clk;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [15:0]       fetch_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [15:0]       imem_wdata;
    logic              cpu_stall;
    logic              pc_load;
    logic [15:0]       pc_value;
    logic              err;

    imem_boot_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .fetch_pc   (fetch_pc),
        .imem_addr  (imem_addr),
        .imem_we    (imem_we),
        .imem_wdata (imem_wdata),
        .cpu_stall  (cpu_stall),
        .pc_load    (pc_load),
        .pc_value   (pc_value),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- monitor
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] pcl_q[$];
    int          stall_cycles = 0;

    always @(negedge clk) begin
        if (imem_we) wr_q.push_back('{addr: imem_addr, data: imem_wdata});
        if (pc_load) pcl_q.push_back(pc_value);
        if (cpu_stall) stall_cycles++;
    end

    // ---------------------------------------------------------------- checking
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte with one idle cycle after it; called and returns just after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Byte with no gap; the next byte follows on the very next cycle.
    task automatic send_fast(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        string       name;
        int          n;
        logic [7:0]  b [10];
        int          exp_wr;
        logic [11:0] a0;
        logic [15:0] d0;
        logic [11:0] a1;
        logic [15:0] d1;
        int          exp_pcl;
        logic [15:0] exp_pc;
        int          exp_stall;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int w0, p0, s0, n;

        // Bytes are sent with one idle cycle between them; stall counts are
        // the number of cycles from the one after the command byte to START.
        vecs[0] = '{"load2", 9, '{8'hA5, 8'h00, 8'h64, 8'h00, 8'h02, 8'h0D, 8'h00, 8'h0D, 8'h41, 8'h00},
                    2, 12'd100, 16'h0D00, 12'd101, 16'h0D41, 1, 16'd100, 18, 1'b0};
        vecs[1] = '{"bank3", 2, '{8'h5A, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0},
                    0, 12'd0, 16'd0, 12'd0, 16'd0, 1, 16'd300, 3, 1'b0};
        vecs[2] = '{"count0", 5, '{8'hA5, 8'h01, 8'hF4, 8'h00, 8'h00, 0, 0, 0, 0, 0},
                    0, 12'd0, 16'd0, 12'd0, 16'd0, 1, 16'd500, 9, 1'b0};
        vecs[3] = '{"bank10", 2, '{8'h5A, 8'h0A, 0, 0, 0, 0, 0, 0, 0, 0},
                    0, 12'd0, 16'd0, 12'd0, 16'd0, 0, 16'd0, 2, 1'b1};
        vecs[4] = '{"junk", 1, '{8'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                    0, 12'd0, 16'd0, 12'd0, 16'd0, 0, 16'd0, 0, 1'b1};
        vecs[5] = '{"bank9", 2, '{8'h5A, 8'h09, 0, 0, 0, 0, 0, 0, 0, 0},
                    0, 12'd0, 16'd0, 12'd0, 16'd0, 1, 16'd900, 3, 1'b0};
        vecs[6] = '{"bank0", 2, '{8'h5A, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0},
                    0, 12'd0, 16'd0, 12'd0, 16'd0, 0, 16'd0, 2, 1'b1};

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        fetch_pc = 16'hABCD;

        // Reset state
        #7;
        check("rst_we",     32'(imem_we),    32'd0);
        check("rst_stall",  32'(cpu_stall),  32'd0);
        check("rst_pcload", 32'(pc_load),    32'd0);
        check("rst_pcval",  32'(pc_value),   32'd0);
        check("rst_wdata",  32'(imem_wdata), 32'd0);
        check("rst_err",    32'(err),        32'd0);
        check("rst_addr",   32'(imem_addr),  32'h0BCD);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(2);

        // Table-driven commands
        foreach (vecs[v]) begin
            w0 = wr_q.size();
            p0 = pcl_q.size();
            s0 = stall_cycles;
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[i]);
            idle_cycles(4);
            check({vecs[v].name, "_nwr"}, 32'(wr_q.size() - w0), 32'(vecs[v].exp_wr));
            if (vecs[v].exp_wr > 0 && wr_q.size() > w0) begin
                check({vecs[v].name, "_a0"}, 32'(wr_q[w0].addr), 32'(vecs[v].a0));
                check({vecs[v].name, "_d0"}, 32'(wr_q[w0].data), 32'(vecs[v].d0));
            end
            if (vecs[v].exp_wr > 1 && wr_q.size() > w0 + 1) begin
                check({vecs[v].name, "_a1"}, 32'(wr_q[w0+1].addr), 32'(vecs[v].a1));
                check({vecs[v].name, "_d1"}, 32'(wr_q[w0+1].data), 32'(vecs[v].d1));
            end
            check({vecs[v].name, "_npcl"}, 32'(pcl_q.size() - p0), 32'(vecs[v].exp_pcl));
            if (vecs[v].exp_pcl > 0 && pcl_q.size() > p0)
                check({vecs[v].name, "_pc"}, 32'(pcl_q[p0]), 32'(vecs[v].exp_pc));
            check({vecs[v].name, "_stall"}, 32'(stall_cycles - s0), 32'(vecs[v].exp_stall));
            check({vecs[v].name, "_err"}, 32'(err), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_idle"}, 32'(cpu_stall), 32'd0);
        end

        // Back-to-back bytes with load pointer wrap: 0x1122@FFF, 0x3344@000.
        // The 0x33 byte arrives during the first WRITE cycle.
        w0 = wr_q.size();
        p0 = pcl_q.size();
        send_fast(8'hA5); send_fast(8'h0F); send_fast(8'hFF);
        send_fast(8'h00); send_fast(8'h02);
        send_fast(8'h11); send_fast(8'h22); send_fast(8'h33); send_fast(8'h44);
        idle_cycles(4);
        check("wrap_nwr", 32'(wr_q.size() - w0), 32'd2);
        if (wr_q.size() >= w0 + 2) begin
            check("wrap_a0", 32'(wr_q[w0].addr),   32'h0FFF);
            check("wrap_d0", 32'(wr_q[w0].data),   32'h1122);
            check("wrap_a1", 32'(wr_q[w0+1].addr), 32'h0000);
            check("wrap_d1", 32'(wr_q[w0+1].data), 32'h3344);
        end
        check("wrap_npcl", 32'(pcl_q.size() - p0), 32'd1);
        if (pcl_q.size() > p0) check("wrap_pc", 32'(pcl_q[p0]), 32'h0FFF);
        check("wrap_err", 32'(err), 32'd0);

        // Timeout: abort exactly TIMEOUT cycles after the last accepted byte.
        w0 = wr_q.size();
        p0 = pcl_q.size();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_fast(8'h64);
        n = 0;
        while (!err && n < 4 * TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(TIMEOUT));
        check("tmo_err",    32'(err), 32'd1);
        check("tmo_stall",  32'(cpu_stall), 32'd0);
        idle_cycles(2);
        check("tmo_npcl", 32'(pcl_q.size() - p0), 32'd0);
        check("tmo_nwr",  32'(wr_q.size() - w0), 32'd0);
        p0 = pcl_q.size();
        send_byte(8'h5A);
        check("tmo_clr", 32'(err), 32'd0);
        send_byte(8'h01);
        idle_cycles(3);
        check("tmo_run_npcl", 32'(pcl_q.size() - p0), 32'd1);
        if (pcl_q.size() > p0) check("tmo_run_pc", 32'(pcl_q[p0]), 32'd100);

        // Asynchronous reset while waiting for the low data byte.
        w0 = wr_q.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h64);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
        check("pre_rst_stall", 32'(cpu_stall), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_stall",  32'(cpu_stall),  32'd0);
        check("arst_we",     32'(imem_we),    32'd0);
        check("arst_pcval",  32'(pc_value),   32'd0);
        check("arst_wdata",  32'(imem_wdata), 32'd0);
        check("arst_err",    32'(err),        32'd0);
        check("arst_addr",   32'(imem_addr),  32'h0BCD);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(1);
        s0 = stall_cycles;
        send_byte(8'h34);
        idle_cycles(2);
        check("arst_nwr",   32'(wr_q.size() - w0), 32'd0);
        check("arst_idle",  32'(stall_cycles - s0), 32'd0);
        p0 = pcl_q.size();
        send_byte(8'h5A); send_byte(8'h02);
        idle_cycles(3);
        check("arst_run_npcl", 32'(pcl_q.size() - p0), 32'd1);
        if (pcl_q.size() > p0) check("arst_run_pc", 32'(pcl_q[p0]), 32'd200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
